// File: rtl/sdram_arbit_if.sv
// Source-side bus between the arbiter and the init, refresh, write and read sub-modules.
interface sdram_arbit_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
);
  logic [3:0]        init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;
  logic              init_end;

  logic              aref_req;
  logic              aref_end;
  logic [3:0]        aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;
  logic              aref_en;

  logic              wr_req;
  logic              wr_end;
  logic [3:0]        wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sdram_en;
  logic [DQ_W-1:0]   wr_data;
  logic              wr_en;

  logic              rd_req;
  logic              rd_end;
  logic [3:0]        rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DQ_W-1:0]   rd_sdram_data;

  modport master (
    output init_cmd, init_ba, init_addr, init_end,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en, rd_sdram_data
  );

  modport slave (
    input  init_cmd, init_ba, init_addr, init_end,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en, rd_sdram_data
  );
endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init owns the pins until init_end, then fixed-priority
// refresh > write > read grants, always separated by at least one NOP cycle.
module sdram_arbit #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2,
  parameter int DQ_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  sdram_arbit_if.slave      bus,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cmd;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= INIT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:  if (bus.init_end) state_nxt = ARBIT;
      ARBIT: begin
        if      (bus.aref_req) state_nxt = AREF;
        else if (bus.wr_req)   state_nxt = WRITE;
        else if (bus.rd_req)   state_nxt = READ;
      end
      AREF:  if (bus.aref_end) state_nxt = ARBIT;
      WRITE: if (bus.wr_end)   state_nxt = ARBIT;
      READ:  if (bus.rd_end)   state_nxt = ARBIT;
      default: state_nxt = INIT;
    endcase
  end

  assign bus.aref_en = (state == AREF);
  assign bus.wr_en   = (state == WRITE);
  assign bus.rd_en   = (state == READ);

  always_comb begin
    cmd        = 4'b0111;
    sdram_ba   = '1;
    sdram_addr = '1;
    case (state)
      INIT: begin
        cmd        = bus.init_cmd;
        sdram_ba   = bus.init_ba;
        sdram_addr = bus.init_addr;
      end
      AREF: begin
        cmd        = bus.aref_cmd;
        sdram_ba   = bus.aref_ba;
        sdram_addr = bus.aref_addr;
      end
      WRITE: begin
        cmd        = bus.wr_cmd;
        sdram_ba   = bus.wr_ba;
        sdram_addr = bus.wr_addr;
      end
      READ: begin
        cmd        = bus.rd_cmd;
        sdram_ba   = bus.rd_ba;
        sdram_addr = bus.rd_addr;
      end
      default: ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;

  assign sdram_dq          = (state == WRITE && bus.wr_sdram_en) ? bus.wr_data : 'z;
  assign bus.rd_sdram_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: init lockout, refresh, priority order, DQ drive, reset mid-write.
module tb_sdram_arbit;
  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DQ_W   = 16;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  wire  [DQ_W-1:0]   sdram_dq;
  logic [DQ_W-1:0]   dq_drv;
  logic              dq_drv_en;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  sdram_arbit_if #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) bus ();

  sdram_arbit #(.ADDR_W(ADDR_W), .BA_W(BA_W), .DQ_W(DQ_W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .bus        (bus.slave),
    .sdram_cke  (sdram_cke),
    .sdram_cs_n (sdram_cs_n),
    .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n),
    .sdram_we_n (sdram_we_n),
    .sdram_ba   (sdram_ba),
    .sdram_addr (sdram_addr),
    .sdram_dq   (sdram_dq)
  );

  // Stand-in for the SDRAM device driving DQ while the controller must be released.
  assign sdram_dq = dq_drv_en ? dq_drv : 'z;

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic [3:0] c, input logic [1:0] b,
                           input logic [12:0] a);
    check({tag, ".cmd"},  {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, c});
    check({tag, ".ba"},   {30'd0, sdram_ba}, {30'd0, b});
    check({tag, ".addr"}, {19'd0, sdram_addr}, {19'd0, a});
  endtask

  task automatic check_grants(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, bus.aref_en, bus.wr_en, bus.rd_en}, {29'd0, exp});
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    dq_drv = 16'h1234; dq_drv_en = 1'b0;
    bus.init_cmd = 4'b0010; bus.init_ba = 2'b01; bus.init_addr = 13'h0400; bus.init_end = 1'b0;
    bus.aref_req = 1'b0; bus.aref_end = 1'b0;
    bus.aref_cmd = 4'b0001; bus.aref_ba = 2'b10; bus.aref_addr = 13'h0ABC;
    bus.wr_req = 1'b0; bus.wr_end = 1'b0;
    bus.wr_cmd = 4'b0100; bus.wr_ba = 2'b00; bus.wr_addr = 13'h0123;
    bus.wr_sdram_en = 1'b0; bus.wr_data = 16'hA5A5;
    bus.rd_req = 1'b0; bus.rd_end = 1'b0;
    bus.rd_cmd = 4'b0101; bus.rd_ba = 2'b11; bus.rd_addr = 13'h0456;

    step(); step();
    check_grants("reset_grants", 3'b000);
    check_bus("reset_bus", 4'b0010, 2'b01, 13'h0400);
    check("cke_reset", {31'd0, sdram_cke}, 32'd1);

    // T5: write request held before init completes must not be granted
    sys_rst_n = 1'b1;
    bus.wr_req = 1'b1;
    repeat (97) step();
    check_grants("preinit_lock", 3'b000);
    check_bus("preinit_bus", 4'b0010, 2'b01, 13'h0400);

    // T1: init_end -> ARBIT NOP on the next cycle
    bus.init_end = 1'b1;
    step();
    check_bus("arbit_nop", 4'b0111, 2'b11, 13'h1FFF);
    check_grants("arbit_grants", 3'b000);
    step();
    check_grants("wr_grant", 3'b010);
    check_bus("wr_bus", 4'b0100, 2'b00, 13'h0123);

    // T4: DQ driven only while wr_sdram_en in WRITE
    bus.wr_sdram_en = 1'b1; #1;
    check("dq_drive", {16'd0, sdram_dq}, {16'd0, 16'hA5A5});
    check("rd_data_follow", {16'd0, bus.rd_sdram_data}, {16'd0, 16'hA5A5});
    bus.wr_sdram_en = 1'b0; dq_drv_en = 1'b1; #1;
    check("dq_release", {16'd0, sdram_dq}, {16'd0, 16'h1234});
    check("rd_data_ext", {16'd0, bus.rd_sdram_data}, {16'd0, 16'h1234});
    dq_drv_en = 1'b0;

    bus.wr_req = 1'b0; bus.wr_end = 1'b1;
    step();
    bus.wr_end = 1'b0;
    check_grants("wr_done", 3'b000);
    check_bus("wr_done_nop", 4'b0111, 2'b11, 13'h1FFF);
    step();
    check_grants("idle_arbit", 3'b000);

    // T2: refresh, with a non-matching end ignored
    bus.aref_req = 1'b1;
    step();
    bus.aref_req = 1'b0;
    check_grants("aref_grant", 3'b100);
    check_bus("aref_bus", 4'b0001, 2'b10, 13'h0ABC);
    bus.wr_end = 1'b1;
    step();
    bus.wr_end = 1'b0;
    check_grants("aref_hold", 3'b100);
    bus.aref_end = 1'b1;
    step();
    bus.aref_end = 1'b0;
    check_grants("aref_done", 3'b000);
    check_bus("aref_done_nop", 4'b0111, 2'b11, 13'h1FFF);

    // T3: all three requests together -> AREF, NOP, WRITE, NOP, READ
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    step();
    check_grants("pri_aref", 3'b100);
    bus.aref_req = 1'b0; bus.aref_end = 1'b1;
    step();
    bus.aref_end = 1'b0;
    check_grants("pri_nop1", 3'b000);
    step();
    check_grants("pri_write", 3'b010);
    bus.wr_req = 1'b0; bus.wr_end = 1'b1;
    step();
    bus.wr_end = 1'b0;
    check_grants("pri_nop2", 3'b000);
    step();
    check_grants("pri_read", 3'b001);
    check_bus("rd_bus", 4'b0101, 2'b11, 13'h0456);
    bus.rd_req = 1'b0; bus.rd_end = 1'b1;
    step();
    bus.rd_end = 1'b0;
    check_grants("rd_done", 3'b000);

    // T6: reset during a write burst
    bus.wr_req = 1'b1;
    step();
    check_grants("t6_write", 3'b010);
    bus.wr_sdram_en = 1'b1;
    bus.init_end = 1'b0;
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    check_grants("rst_mid_wr", 3'b000);
    check_bus("rst_mid_bus", 4'b0010, 2'b01, 13'h0400);
    dq_drv_en = 1'b1; #1;
    check("rst_dq_release", {16'd0, sdram_dq}, {16'd0, 16'h1234});
    dq_drv_en = 1'b0;
    bus.wr_end = 1'b1;
    step();
    bus.wr_end = 1'b0;
    check_grants("spurious_wr_end", 3'b000);
    check_bus("still_init", 4'b0010, 2'b01, 13'h0400);
    check("cke_run", {31'd0, sdram_cke}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
